// File: rtl/dmem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dmem_store_buffer
// Purpose  : Data-memory stage for the pipelined MIPS core. A word-addressed
//            data RAM is fronted by a small FIFO store buffer. Stores retire
//            into the buffer in one cycle. The buffer drains one entry per
//            cycle into RAM whenever the RAM port is not otherwise in use.
//            Loads read RAM combinationally. Pending buffered stores take
//            precedence over the RAM contents.
// Ports    : clk        - clock; all state updates on the rising edge
//            reset      - synchronous, active-high reset
//            memwriteM  - M-stage store request
//            memreadM   - M-stage load request (never set with memwriteM)
//            aluoutM    - byte address; word index = aluoutM[AW+1:2]
//            writedataM - store data
//            readdataM  - combinational load data (0 when no load)
//            stallM     - combinational; core holds M stage while high
//            sb_empty   - 1 when the store buffer holds no entries
// Config   : DMEM_FWD_EN - when defined, a load that hits the buffer gets
//            the youngest matching entry forwarded in the same cycle. When
//            undefined, such a load stalls while the buffer drains.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_store_buffer #(
    parameter int MEM_WORDS = 64,
    parameter int SB_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwriteM,
    input  logic        memreadM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        sb_empty
);

    localparam int c_AW = $clog2(MEM_WORDS);
    localparam int c_PW = $clog2(SB_DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [31:0]     r_mem    [MEM_WORDS];
    logic [c_AW-1:0] r_sbIdx  [SB_DEPTH];
    logic [31:0]     r_sbData [SB_DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;

    logic [c_AW-1:0] w_idx;
    logic            w_full;
    logic            w_empty;
    logic            w_hit;
    logic            w_accept;
    logic            w_drain;
    logic            w_loadBlocksDrain;
    logic            w_unusedAddr;
`ifdef DMEM_FWD_EN
    logic [31:0]     w_fwdData;
`endif

    // Byte offset and high address bits do not select a word, so addresses
    // alias modulo MEM_WORDS*4.
    assign w_idx        = aluoutM[c_AW+1:2];
    assign w_unusedAddr = ^{aluoutM[31:c_AW+2], aluoutM[1:0]};

    assign w_full   = (r_count == c_CW'(SB_DEPTH));
    assign w_empty  = (r_count == '0);
    assign sb_empty = w_empty;

    // Walk the valid entries from oldest to youngest. A later match
    // overwrites an earlier one, so the youngest matching entry wins.
    always_comb begin
        w_hit = 1'b0;
`ifdef DMEM_FWD_EN
        w_fwdData = '0;
`endif
        for (int k = 0; k < SB_DEPTH; k++) begin
            if ((c_CW'(k) < r_count) &&
                (r_sbIdx[r_head + c_PW'(k)] == w_idx)) begin
                w_hit = 1'b1;
`ifdef DMEM_FWD_EN
                w_fwdData = r_sbData[r_head + c_PW'(k)];
`endif
            end
        end
    end

    assign w_accept = !reset && memwriteM && !w_full;

`ifdef DMEM_FWD_EN
    assign w_loadBlocksDrain = memreadM;
`else
    // A load that hits a pending entry must let the buffer drain.
    // Otherwise the stall it raises could never clear.
    assign w_loadBlocksDrain = memreadM && !w_hit;
`endif

    // Accept and drain are mutually exclusive. A store to a full buffer
    // does not accept, so the drain frees a slot for the retry next cycle.
    assign w_drain = !reset && !w_empty && !w_loadBlocksDrain &&
                     !(memwriteM && !w_full);

    always_comb begin
        stallM = 1'b0;
        if (!reset) begin
`ifdef DMEM_FWD_EN
            stallM = memwriteM && w_full;
`else
            stallM = (memwriteM && w_full) || (memreadM && w_hit);
`endif
        end
    end

    always_comb begin
        readdataM = '0;
        if (!reset && memreadM) begin
`ifdef DMEM_FWD_EN
            readdataM = w_hit ? w_fwdData : r_mem[w_idx];
`else
            readdataM = r_mem[w_idx];
`endif
        end
    end

    // Buffer control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_tail  <= r_tail + 1'b1;
                r_count <= r_count + 1'b1;
            end
            if (w_drain) begin
                r_head  <= r_head + 1'b1;
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Entry storage needs no reset; validity comes from head and count.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sbIdx[r_tail]  <= w_idx;
            r_sbData[r_tail] <= writedataM;
        end
    end

    // RAM contents are preserved across reset. w_drain is already
    // gated by reset.
    always_ff @(posedge clk) begin
        if (w_drain) begin
            r_mem[r_sbIdx[r_head]] <= r_sbData[r_head];
        end
    end

endmodule
`default_nettype wire
